// File: rtl/volume_pkg.sv
// volume_pkg: shared types and helpers for the multi-channel volume controller
package volume_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  function automatic int unity(input int lw);
    return 1 << (lw - 1);
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/vol_button_fsm.sv
// vol_button_fsm: button edge detection with hold/auto-repeat producing step pulses
module vol_button_fsm
  import volume_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Vol_up,
  input  logic Vol_down,
  output logic step_up,
  output logic step_down
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES) + 1;
  state_e state_q, state_d;
  dir_e dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic up_prev_q, dn_prev_q;
  logic up_rise, dn_rise, held, hit, step;
  always_comb begin
    up_rise = Vol_up && !up_prev_q;
    dn_rise = Vol_down && !dn_prev_q;
    held = (dir_q == DIR_UP) ? Vol_up : Vol_down;
    hit = cnt_q == CNT_W'(state_q == WAIT_HOLD ? HOLD_CYCLES - 1 : REPEAT_CYCLES - 1);
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    step = 1'b0;
    if (Vol_up && Vol_down) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (up_rise || dn_rise) begin
        step = 1'b1;
        dir_d = up_rise ? DIR_UP : DIR_DOWN;
        cnt_d = '0;
        state_d = WAIT_HOLD;
      end
    end else if (!held) begin
      state_d = IDLE;
    end else if (hit) begin
      step = 1'b1;
      cnt_d = '0;
      state_d = REPEAT;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    step_up = step && dir_d == DIR_UP;
    step_down = step && dir_d == DIR_DOWN;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      dir_q <= DIR_UP;
      cnt_q <= '0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      up_prev_q <= Vol_up;
      dn_prev_q <= Vol_down;
    end
  end
endmodule

// File: rtl/volume_ctrl_mc.sv
// volume_ctrl_mc: per-channel volume levels, mute flags and saturating gain pipeline
module volume_ctrl_mc
  import volume_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_W      = 16,
  parameter int LEVEL_W       = 4,
  parameter int RESET_LEVEL   = 8,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  localparam int CH_W         = $clog2(CHANNELS)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Vol_up,
  input  logic                       Vol_down,
  input  logic                       Mute,
  input  logic [CH_W-1:0]            Ch_sel,
  input  logic signed [SAMPLE_W-1:0] Data_in,
  input  logic                       In_valid,
  input  logic [CH_W-1:0]            In_ch,
  output logic signed [SAMPLE_W-1:0] Data_out,
  output logic                       Out_valid,
  output logic [CH_W-1:0]            Out_ch,
  output logic [LEVEL_W-1:0]         hex_vol,
  output logic [CHANNELS-1:0]        Muted
);
  localparam int PW = SAMPLE_W + LEVEL_W + 1;
  localparam int SHIFT = $clog2(unity(LEVEL_W));
  logic step_up, step_down;
  logic [LEVEL_W-1:0] level_q [CHANNELS];
  logic [LEVEL_W-1:0] level_d [CHANNELS];
  logic [CHANNELS-1:0] muted_q, muted_d;
  logic mute_prev_q;
  logic [LEVEL_W-1:0] hex_q, sel_lvl;
  logic s1_valid_q, out_valid_q;
  logic signed [SAMPLE_W-1:0] s1_data_q, data_q, data_d;
  logic [CH_W-1:0] s1_ch_q, out_ch_q, out_ch_d;
  logic [LEVEL_W-1:0] s1_gain_q, gain_d;
  logic signed [PW-1:0] prod;
  vol_button_fsm #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_fsm (
    .Clk      (Clk),
    .Reset    (Reset),
    .Vol_up   (Vol_up),
    .Vol_down (Vol_down),
    .step_up  (step_up),
    .step_down(step_down)
  );
  always_comb begin
    sel_lvl = level_q[Ch_sel];
    level_d = level_q;
    level_d[Ch_sel] = (step_up && sel_lvl != '1) ? sel_lvl + 1'b1 :
                      (step_down && sel_lvl != '0) ? sel_lvl - 1'b1 : sel_lvl;
    muted_d = muted_q ^ (CHANNELS'(Mute && !mute_prev_q) << Ch_sel);
    // gain is captured from the pre-update level so a same-cycle step never affects this sample
    gain_d = muted_q[In_ch] ? '0 : level_q[In_ch];
    prod = PW'(s1_data_q) * PW'($signed({1'b0, s1_gain_q}));
    data_d = s1_valid_q ? SAMPLE_W'(saturate(64'(prod >>> SHIFT), SAMPLE_W)) : data_q;
    out_ch_d = s1_valid_q ? s1_ch_q : out_ch_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      level_q <= '{default: LEVEL_W'(RESET_LEVEL)};
      muted_q <= '0;
      mute_prev_q <= 1'b0;
      hex_q <= LEVEL_W'(RESET_LEVEL);
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_ch_q <= '0;
      s1_gain_q <= '0;
      out_valid_q <= 1'b0;
      data_q <= '0;
      out_ch_q <= '0;
    end else begin
      level_q <= level_d;
      muted_q <= muted_d;
      mute_prev_q <= Mute;
      hex_q <= sel_lvl;
      s1_valid_q <= In_valid;
      s1_data_q <= Data_in;
      s1_ch_q <= In_ch;
      s1_gain_q <= gain_d;
      out_valid_q <= s1_valid_q;
      data_q <= data_d;
      out_ch_q <= out_ch_d;
    end
  end
  assign Data_out = data_q;
  assign Out_valid = out_valid_q;
  assign Out_ch = out_ch_q;
  assign hex_vol = hex_q;
  assign Muted = muted_q;
endmodule

// File: tb/tb_volume_ctrl_mc.sv
// tb_volume_ctrl_mc: directed self-checking bench for volume_ctrl_mc
module tb_volume_ctrl_mc;
  import volume_pkg::*;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Vol_up = 1'b0;
  logic Vol_down = 1'b0;
  logic Mute = 1'b0;
  logic [0:0] Ch_sel = 1'b0;
  logic signed [15:0] Data_in = '0;
  logic In_valid = 1'b0;
  logic [0:0] In_ch = 1'b0;
  logic signed [15:0] Data_out;
  logic Out_valid;
  logic [0:0] Out_ch;
  logic [3:0] hex_vol;
  logic [1:0] Muted;
  int tests = 0;
  int fails = 0;
  volume_ctrl_mc dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Vol_up   (Vol_up),
    .Vol_down (Vol_down),
    .Mute     (Mute),
    .Ch_sel   (Ch_sel),
    .Data_in  (Data_in),
    .In_valid (In_valid),
    .In_ch    (In_ch),
    .Data_out (Data_out),
    .Out_valid(Out_valid),
    .Out_ch   (Out_ch),
    .hex_vol  (hex_vol),
    .Muted    (Muted)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic send_sample(input logic ch, input logic signed [15:0] d);
    In_ch = ch;
    Data_in = d;
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    tick();
  endtask
  task automatic press(input logic u, input logic d);
    Vol_up = u;
    Vol_down = d;
    tick();
    Vol_up = 1'b0;
    Vol_down = 1'b0;
    tick();
  endtask
  task automatic mute_pulse();
    Mute = 1'b1;
    tick();
    Mute = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tests++;
    if (hex_vol !== 4'd8) begin fails++; $display("FAIL reset_hex: got %0d want 8", hex_vol); end
    tests++;
    if (Out_valid !== 1'b0 || Data_out !== 16'sd0 || Out_ch !== 1'b0) begin
      fails++; $display("FAIL reset_out: valid %0b data %0d ch %0d want 0 0 0", Out_valid, Data_out, Out_ch);
    end
    tests++;
    if (Muted !== 2'b00) begin fails++; $display("FAIL reset_muted: got %b want 00", Muted); end
  endtask
  task automatic test_passthrough();
    Ch_sel = 1'b0;
    send_sample(1'b0, 16'sd1000);
    tests++;
    if (Out_valid !== 1'b1 || Data_out !== 16'sd1000 || Out_ch !== 1'b0) begin
      fails++; $display("FAIL unity: valid %0b data %0d ch %0d want 1 1000 0", Out_valid, Data_out, Out_ch);
    end
    tick();
    tests++;
    if (Out_valid !== 1'b0 || Data_out !== 16'sd1000) begin
      fails++; $display("FAIL hold_out: valid %0b data %0d want 0 1000", Out_valid, Data_out);
    end
  endtask
  task automatic test_steps();
    Ch_sel = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      press(1'b1, 1'b0);
      tests++;
      if (hex_vol !== 4'((8 + i > 15) ? 15 : 8 + i)) begin
        fails++; $display("FAIL up_step_%0d: got %0d want %0d", i, hex_vol, (8 + i > 15) ? 15 : 8 + i);
      end
    end
    Ch_sel = 1'b0;
    tick();
    tests++;
    if (hex_vol !== 4'd8) begin fails++; $display("FAIL ch0_untouched: got %0d want 8", hex_vol); end
  endtask
  task automatic test_auto_repeat();
    Ch_sel = 1'b0;
    Vol_up = 1'b1;
    repeat (10) tick();
    tests++;
    if (hex_vol !== 4'd10) begin fails++; $display("FAIL hold_first_repeat: got %0d want 10", hex_vol); end
    repeat (10) tick();
    Vol_up = 1'b0;
    tick();
    tick();
    tests++;
    if (hex_vol !== 4'd12) begin fails++; $display("FAIL hold_20: got %0d want 12", hex_vol); end
    tests++;
    if (dut.u_fsm.state_q !== IDLE) begin fails++; $display("FAIL release_idle: got %0d want %0d", dut.u_fsm.state_q, IDLE); end
  endtask
  task automatic test_saturation();
    repeat (3) press(1'b1, 1'b0);
    tests++;
    if (hex_vol !== 4'd15) begin fails++; $display("FAIL ch0_max: got %0d want 15", hex_vol); end
    send_sample(1'b0, 16'sd20000);
    tests++;
    if (Out_valid !== 1'b1 || Data_out !== 16'sd32767) begin
      fails++; $display("FAIL sat_pos: valid %0b data %0d want 1 32767", Out_valid, Data_out);
    end
    send_sample(1'b0, -16'sd20000);
    tests++;
    if (Data_out !== -16'sd32768) begin fails++; $display("FAIL sat_neg: got %0d want -32768", Data_out); end
    repeat (16) press(1'b0, 1'b1);
    tests++;
    if (hex_vol !== 4'd0) begin fails++; $display("FAIL ch0_min: got %0d want 0", hex_vol); end
    send_sample(1'b0, 16'sd20000);
    tests++;
    if (Data_out !== 16'sd0) begin fails++; $display("FAIL level0: got %0d want 0", Data_out); end
  endtask
  task automatic test_mute();
    Ch_sel = 1'b1;
    mute_pulse();
    tests++;
    if (Muted !== 2'b10) begin fails++; $display("FAIL mute_on: got %b want 10", Muted); end
    send_sample(1'b1, 16'sd1000);
    tests++;
    if (Out_valid !== 1'b1 || Data_out !== 16'sd0 || Out_ch !== 1'b1) begin
      fails++; $display("FAIL muted_sample: valid %0b data %0d ch %0d want 1 0 1", Out_valid, Data_out, Out_ch);
    end
    press(1'b0, 1'b1);
    tests++;
    if (hex_vol !== 4'd14 || Muted !== 2'b10) begin
      fails++; $display("FAIL muted_down: hex %0d muted %b want 14 10", hex_vol, Muted);
    end
    mute_pulse();
    tests++;
    if (Muted !== 2'b00) begin fails++; $display("FAIL mute_off: got %b want 00", Muted); end
    send_sample(1'b1, 16'sd1000);
    tests++;
    if (Data_out !== 16'sd1750) begin fails++; $display("FAIL unmuted_sample: got %0d want 1750", Data_out); end
  endtask
  task automatic test_back_to_back();
    In_valid = 1'b1;
    In_ch = 1'b1;
    Data_in = 16'sd800;
    tick();
    In_ch = 1'b0;
    Data_in = 16'sd500;
    tick();
    tests++;
    if (Out_valid !== 1'b1 || Data_out !== 16'sd1400 || Out_ch !== 1'b1) begin
      fails++; $display("FAIL b2b_0: valid %0b data %0d ch %0d want 1 1400 1", Out_valid, Data_out, Out_ch);
    end
    In_ch = 1'b1;
    Data_in = -16'sd800;
    tick();
    tests++;
    if (Out_valid !== 1'b1 || Data_out !== 16'sd0 || Out_ch !== 1'b0) begin
      fails++; $display("FAIL b2b_1: valid %0b data %0d ch %0d want 1 0 0", Out_valid, Data_out, Out_ch);
    end
    In_valid = 1'b0;
    tick();
    tests++;
    if (Out_valid !== 1'b1 || Data_out !== -16'sd1400 || Out_ch !== 1'b1) begin
      fails++; $display("FAIL b2b_2: valid %0b data %0d ch %0d want 1 -1400 1", Out_valid, Data_out, Out_ch);
    end
  endtask
  task automatic test_chsel_during_repeat();
    Ch_sel = 1'b0;
    Vol_up = 1'b1;
    repeat (4) tick();
    Ch_sel = 1'b1;
    repeat (6) tick();
    Vol_up = 1'b0;
    tick();
    tick();
    tests++;
    if (hex_vol !== 4'd15) begin fails++; $display("FAIL repeat_new_ch: got %0d want 15", hex_vol); end
    Ch_sel = 1'b0;
    tick();
    tests++;
    if (hex_vol !== 4'd1) begin fails++; $display("FAIL repeat_old_ch: got %0d want 1", hex_vol); end
  endtask
  task automatic test_both_buttons();
    Ch_sel = 1'b0;
    Vol_up = 1'b1;
    Vol_down = 1'b1;
    repeat (3) tick();
    Vol_up = 1'b0;
    Vol_down = 1'b0;
    tick();
    tick();
    tests++;
    if (hex_vol !== 4'd1) begin fails++; $display("FAIL both_buttons: got %0d want 1", hex_vol); end
    tests++;
    if (dut.u_fsm.state_q !== IDLE) begin fails++; $display("FAIL both_idle: got %0d want %0d", dut.u_fsm.state_q, IDLE); end
  endtask
  task automatic test_reset_midstream();
    In_ch = 1'b0;
    Data_in = 16'sd100;
    In_valid = 1'b1;
    tick();
    Data_in = 16'sd200;
    tick();
    In_valid = 1'b0;
    tests++;
    if (Out_valid !== 1'b1) begin fails++; $display("FAIL inflight_valid: got %0b want 1", Out_valid); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests++;
    if (Out_valid !== 1'b0 || Data_out !== 16'sd0) begin
      fails++; $display("FAIL reset_flush: valid %0b data %0d want 0 0", Out_valid, Data_out);
    end
    tick();
    tests++;
    if (Out_valid !== 1'b0 || hex_vol !== 4'd8) begin
      fails++; $display("FAIL reset_after: valid %0b hex %0d want 0 8", Out_valid, hex_vol);
    end
    Ch_sel = 1'b1;
    tick();
    tests++;
    if (hex_vol !== 4'd8) begin fails++; $display("FAIL reset_ch1: got %0d want 8", hex_vol); end
  endtask
  initial begin
    test_reset();
    test_passthrough();
    test_steps();
    test_auto_repeat();
    test_saturation();
    test_mute();
    test_back_to_back();
    test_chsel_during_repeat();
    test_both_buttons();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
